// File: rtl/mips32_prog_loader.sv
// rtl/mips32_prog_loader.sv - handshaked program loader / run controller for the MIPS32 core
// Optional cycle counter: define MIPS32_LOADER_CYCLE_COUNT_EN to report execution cycles on RUN.
module mips32_prog_loader #(
    parameter int MEM_AW = 10,
    parameter int DW     = 32
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [MEM_AW-1:0] cmd_addr,
    input  logic [DW-1:0]     cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DW-1:0]     rsp_data,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [DW-1:0]     mem_wdata,
    output logic              reg_we,
    output logic              reg_re,
    output logic [4:0]        reg_addr,
    output logic [DW-1:0]     reg_wdata,
    input  logic [DW-1:0]     reg_rdata,
    output logic              core_run,
    output logic              pc_clear,
    input  logic              core_halted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_RD_REQ,
        S_RD_WAIT,
        S_RESP,
        S_RUN_START,
        S_RUN,
        S_RUN_DONE
    } state_t;

    localparam logic [1:0] OP_WR_MEM = 2'b00;
    localparam logic [1:0] OP_WR_REG = 2'b01;
    localparam logic [1:0] OP_RD_REG = 2'b10;

    state_t              state_q;
    logic                cmd_ready_q;
    logic                rsp_valid_q;
    logic [DW-1:0]       rsp_data_q;
    logic                mem_we_q;
    logic [MEM_AW-1:0]   mem_addr_q;
    logic [DW-1:0]       mem_wdata_q;
    logic                reg_we_q;
    logic                reg_re_q;
    logic [4:0]          reg_addr_q;
    logic [DW-1:0]       reg_wdata_q;
    logic                core_run_q;
    logic                pc_clear_q;
    logic [DW-1:0]       run_result;

`ifdef MIPS32_LOADER_CYCLE_COUNT_EN
    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    // Saturating increment so very long runs report all-ones rather than wrapping.
    assign cnt_d      = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
    assign run_result = DW'(cnt_q);

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 32'd0;
        end else if (state_q == S_RUN_START) begin
            cnt_q <= 32'd0;
        end else if (state_q == S_RUN) begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign run_result = '0;
`endif

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            reg_we_q    <= 1'b0;
            reg_re_q    <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            core_run_q  <= 1'b0;
            pc_clear_q  <= 1'b0;
        end else begin
            mem_we_q   <= 1'b0;
            reg_we_q   <= 1'b0;
            reg_re_q   <= 1'b0;
            pc_clear_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready_q) begin
                        cmd_ready_q <= 1'b0;
                        case (cmd_op)
                            OP_WR_MEM: begin
                                state_q     <= S_WRITE;
                                mem_we_q    <= 1'b1;
                                mem_addr_q  <= cmd_addr;
                                mem_wdata_q <= cmd_data;
                            end
                            OP_WR_REG: begin
                                // R0 is hardwired: the write slot is spent but no strobe is issued.
                                state_q     <= S_WRITE;
                                reg_we_q    <= (cmd_addr[4:0] != 5'd0);
                                reg_addr_q  <= cmd_addr[4:0];
                                reg_wdata_q <= cmd_data;
                            end
                            OP_RD_REG: begin
                                state_q    <= S_RD_REQ;
                                reg_re_q   <= 1'b1;
                                reg_addr_q <= cmd_addr[4:0];
                            end
                            default: begin
                                state_q    <= S_RUN_START;
                                pc_clear_q <= 1'b1;
                                core_run_q <= 1'b1;
                            end
                        endcase
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end
                S_WRITE: begin
                    state_q     <= S_IDLE;
                    cmd_ready_q <= 1'b1;
                end
                S_RD_REQ: begin
                    state_q <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    rsp_data_q  <= reg_rdata;
                    rsp_valid_q <= 1'b1;
                    state_q     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                S_RUN_START: begin
                    // HALTED may still be stale from the previous run here, so it is not sampled.
                    state_q <= S_RUN;
                end
                S_RUN: begin
                    if (core_halted) begin
                        core_run_q <= 1'b0;
                        state_q    <= S_RUN_DONE;
                    end
                end
                S_RUN_DONE: begin
                    rsp_data_q  <= run_result;
                    rsp_valid_q <= 1'b1;
                    state_q     <= S_RESP;
                end
                default: begin
                    state_q     <= S_IDLE;
                    cmd_ready_q <= 1'b0;
                    rsp_valid_q <= 1'b0;
                    core_run_q  <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign reg_we    = reg_we_q;
    assign reg_re    = reg_re_q;
    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;
    assign core_run  = core_run_q;
    assign pc_clear  = pc_clear_q;

endmodule

// File: tb/tb_mips32_prog_loader.sv
// tb/tb_mips32_prog_loader.sv - randomized self-checking bench for mips32_prog_loader
`timescale 1ns/1ps
module tb_mips32_prog_loader;
    localparam int MEM_AW = 10;
    localparam int DW     = 32;
    localparam logic [1:0] OP_WR_MEM = 2'b00;
    localparam logic [1:0] OP_WR_REG = 2'b01;
    localparam logic [1:0] OP_RD_REG = 2'b10;
    localparam logic [1:0] OP_RUN    = 2'b11;
    localparam int PROG_LEN = 9;

    logic              clk1 = 1'b0;
    logic              rst_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [MEM_AW-1:0] cmd_addr;
    logic [DW-1:0]     cmd_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DW-1:0]     rsp_data;
    logic              mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic              reg_we;
    logic              reg_re;
    logic [4:0]        reg_addr;
    logic [DW-1:0]     reg_wdata;
    logic [DW-1:0]     reg_rdata;
    logic              core_run;
    logic              pc_clear;
    logic              core_halted;

    always #5 clk1 = ~clk1;

    mips32_prog_loader #(.MEM_AW(MEM_AW), .DW(DW)) dut (
        .clk1(clk1), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .reg_we(reg_we), .reg_re(reg_re), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
        .core_run(core_run), .pc_clear(pc_clear), .core_halted(core_halted)
    );

    // Behavioural core: interprets the program at pc_clear, then reports HALTED after a chosen delay.
    logic [31:0] imem [0:1023];
    logic [31:0] rf [0:31];
    int cyc_since = 0;
    int halt_at = 0;
    int halt_extra = 0;

    assign core_halted = !core_run || (cyc_since >= halt_at);

    function automatic int exec_program();
        int pc = 0;
        int n = 0;
        logic [31:0] ins;
        while (n < 64) begin
            ins = imem[pc];
            n++;
            pc++;
            if (ins[31:26] == 6'h3f) break;
            case (ins[31:26])
                6'h00: if (ins[15:11] != 0) rf[ins[15:11]] = rf[ins[25:21]] + rf[ins[20:16]];
                6'h03: if (ins[15:11] != 0) rf[ins[15:11]] = rf[ins[25:21]] | rf[ins[20:16]];
                6'h0a: if (ins[20:16] != 0) rf[ins[20:16]] = rf[ins[25:21]] + {{16{ins[15]}}, ins[15:0]};
                default: ;
            endcase
        end
        return n;
    endfunction

    always @(posedge clk1) begin
        reg_rdata <= reg_re ? rf[reg_addr] : 32'h0BAD_0BAD;
        if (mem_we) imem[mem_addr] = mem_wdata;
        if (reg_we && reg_addr != 5'd0) rf[reg_addr] = reg_wdata;
        if (pc_clear) begin
            halt_at   <= exec_program() + halt_extra;
            cyc_since <= 1;
        end else if (core_run) begin
            cyc_since <= cyc_since + 1;
        end
    end

    logic [31:0] model_rf [0:31];
    logic [31:0] prog [0:PROG_LEN-1];
    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        check({tag, "_rsp_data"}, rsp_data, 0);
        check({tag, "_mem_we"}, 32'(mem_we), 0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 0);
        check({tag, "_mem_wdata"}, mem_wdata, 0);
        check({tag, "_reg_we"}, 32'(reg_we), 0);
        check({tag, "_reg_re"}, 32'(reg_re), 0);
        check({tag, "_reg_addr"}, 32'(reg_addr), 0);
        check({tag, "_reg_wdata"}, reg_wdata, 0);
        check({tag, "_core_run"}, 32'(core_run), 0);
        check({tag, "_pc_clear"}, 32'(pc_clear), 0);
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!cmd_ready && n < 5) begin
            @(negedge clk1);
            n++;
        end
        check(tag, 32'(cmd_ready), 1);
    endtask

    // Called at a negedge; returns at the negedge of the first cycle after acceptance.
    task automatic send_cmd(input logic [1:0] op, input logic [MEM_AW-1:0] addr, input logic [31:0] data);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_data  = data;
        while (!cmd_ready && n < 50) begin
            @(negedge clk1);
            n++;
        end
        check("cmd_accept", 32'(cmd_ready), 1);
        @(negedge clk1);
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_addr  = MEM_AW'($urandom);
        cmd_data  = $urandom;
    endtask

    task automatic do_write(input logic [1:0] op, input logic [MEM_AW-1:0] addr, input logic [31:0] data);
        send_cmd(op, addr, data);
        if (op == OP_WR_MEM) begin
            check("wr_mem_we", 32'(mem_we), 1);
            check("wr_mem_addr", 32'(mem_addr), 32'(addr));
            check("wr_mem_wdata", mem_wdata, data);
            check("wr_mem_no_reg_we", 32'(reg_we), 0);
        end else begin
            check("wr_reg_we", 32'(reg_we), (addr[4:0] != 5'd0) ? 32'd1 : 32'd0);
            check("wr_reg_wdata", reg_wdata, data);
            check("wr_reg_no_mem_we", 32'(mem_we), 0);
            if (addr[4:0] != 5'd0) begin
                check("wr_reg_addr", 32'(reg_addr), 32'(addr[4:0]));
                model_rf[addr[4:0]] = data;
            end
        end
        check("wr_no_rsp", 32'(rsp_valid), 0);
        @(negedge clk1);
        check("wr_strobe_end", 32'({mem_we, reg_we}), 0);
        check("wr_ready_again", 32'(cmd_ready), 1);
    endtask

    task automatic do_read(input logic [MEM_AW-1:0] addr, input int hold);
        logic [31:0] exp;
        exp = model_rf[addr[4:0]];
        rsp_ready = (hold == 0);
        send_cmd(OP_RD_REG, addr, $urandom);
        check("rd_reg_re", 32'(reg_re), 1);
        check("rd_reg_addr", 32'(reg_addr), 32'(addr[4:0]));
        @(negedge clk1);
        check("rd_re_pulse", 32'(reg_re), 0);
        check("rd_not_early", 32'(rsp_valid), 0);
        @(negedge clk1);
        check("rd_rsp_valid", 32'(rsp_valid), 1);
        check("rd_rsp_data", rsp_data, exp);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk1);
            check("bp_rsp_valid", 32'(rsp_valid), 1);
            check("bp_rsp_data", rsp_data, exp);
            check("bp_cmd_ready", 32'(cmd_ready), 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk1);
        check("rd_rsp_done", 32'(rsp_valid), 0);
        check("rd_ready_again", 32'(cmd_ready), 1);
    endtask

    task automatic model_after_run();
        model_rf[1]  = 32'd10;
        model_rf[2]  = 32'd20;
        model_rf[3]  = 32'd25;
        model_rf[4]  = 32'd30;
        model_rf[5]  = 32'd55;
        model_rf[15] = model_rf[7];
    endtask

    task automatic run_prog(input int extra);
        int lat = 1;
        int runc = 0;
        int pcc = 0;
        logic [31:0] exp_rsp;
        halt_extra = extra;
        rsp_ready  = 1'b1;
        send_cmd(OP_RUN, MEM_AW'($urandom), $urandom);
        check("run_pc_clear", 32'(pc_clear), 1);
        check("run_core_run_start", 32'(core_run), 1);
        while (!rsp_valid && lat < 300) begin
            @(negedge clk1);
            lat++;
            if (pc_clear) pcc++;
            if (core_run) runc++;
        end
`ifdef MIPS32_LOADER_CYCLE_COUNT_EN
        exp_rsp = 32'(PROG_LEN + extra);
`else
        exp_rsp = 32'd0;
`endif
        check("run_rsp_valid", 32'(rsp_valid), 1);
        check("run_latency", 32'(lat), 32'(PROG_LEN + extra + 3));
        check("run_core_run_cycles", 32'(runc), 32'(PROG_LEN + extra));
        check("run_extra_pc_clear", 32'(pcc), 0);
        check("run_rsp_data", rsp_data, exp_rsp);
        @(negedge clk1);
        check("run_rsp_done", 32'(rsp_valid), 0);
        check("run_ready_again", 32'(cmd_ready), 1);
        model_after_run();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        prog[0] = 32'h2801000a; prog[1] = 32'h28020014; prog[2] = 32'h28030019;
        prog[3] = 32'h0ce77800; prog[4] = 32'h0ce77800; prog[5] = 32'h00222000;
        prog[6] = 32'h0ce77800; prog[7] = 32'h00832800; prog[8] = 32'hfc000000;
        for (int i = 0; i < 1024; i++) imem[i] = 32'h0;
        for (int i = 0; i < 32; i++) begin
            rf[i] = 32'h0;
            model_rf[i] = 32'h0;
        end
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = '0; cmd_data = '0;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk1);
        check_outputs_zero("por");
        rst_n = 1'b1;
        wait_ready("ready_after_por");

        // Reset asserted between clock edges while a write strobe is high.
        send_cmd(OP_WR_MEM, 10'd300, 32'h12345678);
        check("pre_rst_mem_we", 32'(mem_we), 1);
        #2 rst_n = 1'b0;
        #1 check_outputs_zero("mid_rst");
        @(negedge clk1);
        rst_n = 1'b1;
        wait_ready("ready_after_mid_rst");

        for (int i = 0; i < PROG_LEN; i++) do_write(OP_WR_MEM, MEM_AW'(i), prog[i]);

        run_prog(int'($urandom_range(1, 20)));

        for (int i = 1; i <= 5; i++) do_read(MEM_AW'(i), 0);
        do_read(MEM_AW'(3), 5);

        do_write(OP_WR_REG, MEM_AW'(10'h0E0), 32'hDEADBEEF);
        do_read(MEM_AW'(10'h040), 0);

        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 3))
                0: do_write(OP_WR_MEM, MEM_AW'($urandom_range(16, 1023)), $urandom);
                1: do_write(OP_WR_REG, MEM_AW'($urandom), $urandom);
                2: do_read(MEM_AW'($urandom), int'($urandom_range(0, 3)));
                default: run_prog(int'($urandom_range(0, 15)));
            endcase
        end

        // Reset two cycles into RUN: the run and its response are abandoned.
        halt_extra = 60;
        rsp_ready  = 1'b1;
        send_cmd(OP_RUN, '0, '0);
        @(negedge clk1);
        @(negedge clk1);
        check("run_before_rst", 32'(core_run), 1);
        #2 rst_n = 1'b0;
        #1 check("rst_run_core_run", 32'(core_run), 0);
        check("rst_run_rsp_valid", 32'(rsp_valid), 0);
        check("rst_run_pc_clear", 32'(pc_clear), 0);
        @(negedge clk1);
        rst_n = 1'b1;
        wait_ready("ready_after_run_rst");
        check("no_stale_rsp", 32'(rsp_valid), 0);
        model_after_run();
        do_read(MEM_AW'(1), 0);
        do_read(MEM_AW'(5), 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mips32_prog_loader.md
# mips32_prog_loader

Single-clock command responder that loads programs into the pipelined MIPS32 core and controls its execution. It writes instruction memory, writes and reads the register file, and starts the core from PC 0. A run completes when the core reports HALTED. The block sits between an external host or bench driver and the core's memory, register-file and control hooks, and replaces hierarchical pokes with a handshaked port.

## Interface
Parameters:
- MEM_AW, 10, instruction-memory word-address width
- DW, 32, data width

Ports:
- clk1  input  1  clock; shared with the core's phase-1 clock
- rst_n  input  1  reset; asynchronous, active-low
- cmd_valid  input  1  command offered
- cmd_ready  output  1  command accepted when high together with cmd_valid
- cmd_op  input  2  00 WR_MEM, 01 WR_REG, 10 RD_REG, 11 RUN
- cmd_addr  input  MEM_AW  memory word address; bits [4:0] give the register index
- cmd_data  input  DW  write data
- rsp_valid  output  1  response available
- rsp_ready  input  1  host takes the response
- rsp_data  output  DW  response payload
- mem_we  output  1  instruction-memory write strobe
- mem_addr  output  MEM_AW  memory address
- mem_wdata  output  DW  memory write data
- reg_we  output  1  register-file write strobe
- reg_re  output  1  register-file read strobe
- reg_addr  output  5  register index
- reg_wdata  output  DW  register write data
- reg_rdata  input  DW  register read data, valid one cycle after reg_re
- core_run  output  1  high while the core executes; low holds HALTED=1
- pc_clear  output  1  one-cycle pulse that forces PC=0 and TAKEN_BRANCH=0
- core_halted  input  1  core HALTED flag

## Operation
- States: IDLE, WRITE, RD_REQ, RD_WAIT, RESP, RUN_START, RUN, RUN_DONE.
- IDLE: cmd_ready=1, and it is high only in this state. On acceptance:
  - WR_MEM or WR_REG goes to WRITE.
  - RD_REG goes to RD_REQ.
  - RUN goes to RUN_START.
- The address and data of the accepted command are registered.
- WRITE: asserts either mem_we or reg_we for exactly one cycle, then returns to IDLE. No response is produced.
- WR_REG to index 0: reg_we stays low. R0 is hardwired, so the write is silently dropped but still consumes the WRITE cycle.
- RD_REQ: reg_re=1 with reg_addr set for one cycle, then RD_WAIT.
- RD_WAIT: captures reg_rdata into rsp_data, then RESP.
- RESP: rsp_valid=1, with rsp_data held stable until rsp_ready. The cycle rsp_valid&&rsp_ready is seen, the block returns to IDLE.
- RUN_START: pc_clear=1 and core_run=1 for one cycle. core_halted is ignored in this cycle. The cycle counter is cleared to 0.
- RUN: core_run=1. The counter increments every cycle and saturates at 32'hFFFFFFFF. When core_halted=1 is sampled, the block goes to RUN_DONE.
- RUN_DONE: core_run=0, rsp_data=counter (see Configuration), then RESP.
- cmd_addr wider than the memory is truncated to MEM_AW bits. Register reads and writes use only cmd_addr[4:0].
- There is no command queue. The host must wait for cmd_ready.

## Timing
- Reset values: cmd_ready=0 while in reset, then 1 from the first IDLE cycle. All other outputs are 0: rsp_valid, rsp_data, mem_we, mem_addr, mem_wdata, reg_we, reg_re, reg_addr, reg_wdata, core_run, pc_clear. The counter is 0 and the state is IDLE.
- Write latency: the strobe appears in the cycle after acceptance. The next command can be accepted 2 cycles after the previous one.
- Read latency: rsp_valid rises 3 cycles after acceptance (RD_REQ, RD_WAIT, RESP).
- RUN: core_halted seen in cycle N of RUN gives rsp_data=N. rsp_valid rises 2 cycles after that.
- Reset asserted mid-run: core_run drops to 0 immediately (asynchronous), the core is held halted, and any pending response is discarded.
- rsp_ready held high before rsp_valid rises: the handshake completes in the first RESP cycle.

## Configuration
- MIPS32_LOADER_CYCLE_COUNT_EN defined: the 32-bit saturating counter is built, and the RUN response carries the execution cycle count.
- Not defined: the counter is removed, and the RUN response carries 32'h0. Handshake and timing are unchanged.

## Test plan
- Reset: drive rst_n=0 mid-cycle -> all outputs 0 immediately. After release, cmd_ready=1.
- Program load: issue WR_MEM to addresses 0..8 with 2801000a, 28020014, 28030019, 0ce77800, 0ce77800, 00222000, 0ce77800, 00832800, fc000000 -> nine single-cycle mem_we pulses with matching address/data, and no rsp_valid.
- Run: issue RUN on the loaded core -> one pc_clear pulse, core_run high until HALTED. A response arrives; with the macro on it equals the cycle count and is nonzero, with the macro off it is 0.
- Readback: RD_REG to indices 1..5 -> rsp_data 10, 20, 25, 30, 55, each 3 cycles after acceptance.
- Backpressure and R0: hold rsp_ready=0 for 5 cycles -> rsp_data stable and cmd_ready=0 throughout. WR_REG index 0 with 32'hDEADBEEF -> reg_we stays 0.
- Reset during RUN: assert rst_n=0 two cycles into RUN -> core_run=0 and rsp_valid=0. A following RD_REG is accepted normally.
